qeciphy_tx_framer: RTL and testbench

Transmit-side framer. It builds the 64-word frame that the RX boundary/alignment logic locks onto. Slot 0 of every frame carries the FAW word. Every 7th slot after it carries a CRC word supplied by the external CRC engine. All other slots carry user data taken from an AXI-Stream-style slave port, or an idle word when no data is offered. It sits between the user TX stream and the TX CRC engine/PCS gearbox, and drives `faw_boundary_o`/`crc_boundary_o` so downstream blocks know the slot type of every output word.

---
 rtl/qeciphy_tx_framer_if.sv | 30 +++
 rtl/qeciphy_tx_framer.sv | 122 ++++++++++++
 tb/tb_qeciphy_tx_framer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/qeciphy_tx_framer_if.sv
// Bus bundle for qeciphy_tx_framer: user TX stream in, framed word and slot flags out.
interface qeciphy_tx_framer_if;
    logic [63:0] s_tdata_i;
    logic        s_tvalid_i;
    logic        s_tready_o;
    logic [63:0] tdata_o;
    logic        data_valid_o;
    logic        faw_boundary_o;
    logic        crc_boundary_o;

    modport slave (
        input  s_tdata_i,
        input  s_tvalid_i,
        output s_tready_o,
        output tdata_o,
        output data_valid_o,
        output faw_boundary_o,
        output crc_boundary_o
    );

    modport master (
        output s_tdata_i,
        output s_tvalid_i,
        input  s_tready_o,
        input  tdata_o,
        input  data_valid_o,
        input  faw_boundary_o,
        input  crc_boundary_o
    );
endinterface

// File: rtl/qeciphy_tx_framer.sv
// TX framer: 64-slot frame with FAW in slot 0, CRC every 7th slot, user data or idle elsewhere.
// Optional frame counter enabled by QECIPHY_TX_FRAMER_STATS_EN.
package qeciphy_pkg;
    localparam logic [63:0] FAW = 64'hA5F0_C3E1_5A0F_3C1E;
endpackage

// state    | meaning
// DISABLED | framer off, outputs and slot counter held at 0
// START    | one-cycle primer before slot 0 is registered
// RUNNING  | slot counter advances, frame words emitted
module qeciphy_tx_framer #(
    parameter logic [63:0] IDLE_WORD = 64'h0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        enable_i,
    input  logic [63:0] crc_i,
    output logic [15:0] frame_count_o,
    qeciphy_tx_framer_if.slave bus
);
    localparam logic [1:0] DISABLED = 2'd0;
    localparam logic [1:0] START    = 2'd1;
    localparam logic [1:0] RUNNING  = 2'd2;

    logic [1:0]  state_q;
    logic [5:0]  slot_q;
    logic        running;
    logic        slot_faw;
    logic        slot_crc;
    logic        slot_data;
    logic        accept;

    logic [63:0] tdata_q;
    logic        data_valid_q;
    logic        faw_q;
    logic        crc_q;

    assign running   = (state_q == RUNNING);
    assign slot_faw  = (slot_q == 6'd0);
    assign slot_crc  = !slot_faw && ((slot_q % 6'd7) == 6'd0);
    assign slot_data = !slot_faw && !slot_crc;

    // Ready depends on registered state only, never on s_tvalid_i.
    assign bus.s_tready_o = running && slot_data;
    assign accept         = bus.s_tready_o && bus.s_tvalid_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= DISABLED;
        end else if (!enable_i) begin
            state_q <= DISABLED;
        end else begin
            case (state_q)
                DISABLED: state_q <= START;
                START:    state_q <= RUNNING;
                RUNNING:  state_q <= RUNNING;
                default:  state_q <= DISABLED;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            slot_q <= 6'd0;
        end else if (running && enable_i) begin
            slot_q <= slot_q + 6'd1;
        end else begin
            slot_q <= 6'd0;
        end
    end

    // A word handshaken in the last RUNNING cycle is still registered, so nothing is dropped on disable.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tdata_q      <= 64'h0;
            data_valid_q <= 1'b0;
            faw_q        <= 1'b0;
            crc_q        <= 1'b0;
        end else if (running) begin
            faw_q        <= slot_faw;
            crc_q        <= slot_crc;
            data_valid_q <= accept;
            if (slot_faw) begin
                tdata_q <= qeciphy_pkg::FAW;
            end else if (slot_crc) begin
                tdata_q <= crc_i;
            end else if (accept) begin
                tdata_q <= bus.s_tdata_i;
            end else begin
                tdata_q <= IDLE_WORD;
            end
        end else begin
            tdata_q      <= 64'h0;
            data_valid_q <= 1'b0;
            faw_q        <= 1'b0;
            crc_q        <= 1'b0;
        end
    end

    assign bus.tdata_o        = tdata_q;
    assign bus.data_valid_o   = data_valid_q;
    assign bus.faw_boundary_o = faw_q;
    assign bus.crc_boundary_o = crc_q;

`ifdef QECIPHY_TX_FRAMER_STATS_EN
    logic [15:0] frame_count_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            frame_count_q <= 16'h0;
        end else if (state_q == DISABLED) begin
            frame_count_q <= 16'h0;
        end else if (running && slot_faw) begin
            frame_count_q <= frame_count_q + 16'h1;
        end
    end

    assign frame_count_o = frame_count_q;
`else
    assign frame_count_o = 16'h0;
`endif
endmodule

// File: tb/tb_qeciphy_tx_framer.sv
// Self-checking bench for qeciphy_tx_framer against a slot-position reference model.
module tb_qeciphy_tx_framer;
    localparam logic [63:0] FAW_WORD = 64'hA5F0_C3E1_5A0F_3C1E;
    localparam logic [63:0] TB_IDLE  = 64'h1D1E_1D1E_0BAD_F00D;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        enable_i;
    logic [63:0] crc_i;
    logic [15:0] frame_count_o;

    int n_checks = 0;
    int n_fail   = 0;

    qeciphy_tx_framer_if bus();

    qeciphy_tx_framer #(.IDLE_WORD(TB_IDLE)) u_dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .enable_i      (enable_i),
        .crc_i         (crc_i),
        .frame_count_o (frame_count_o),
        .bus           (bus)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit is_data_pos(input int p);
        return (p != 0) && ((p % 7) != 0);
    endfunction

    task automatic test_reset();
        n_checks++; if (bus.tdata_o !== 64'h0) begin n_fail++; $display("FAIL reset_tdata got %h exp 0", bus.tdata_o); end
        n_checks++; if ({bus.data_valid_o, bus.faw_boundary_o, bus.crc_boundary_o} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags got %b exp 000", {bus.data_valid_o, bus.faw_boundary_o, bus.crc_boundary_o}); end
        n_checks++; if (bus.s_tready_o !== 1'b0) begin n_fail++; $display("FAIL reset_tready got %b exp 0", bus.s_tready_o); end
        n_checks++; if (frame_count_o !== 16'h0) begin n_fail++; $display("FAIL reset_fc got %0d exp 0", frame_count_o); end
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        n_checks++; if ({bus.tdata_o, bus.s_tready_o} !== 65'h0) begin
            n_fail++; $display("FAIL post_reset_idle got %h/%b exp 0/0", bus.tdata_o, bus.s_tready_o); end
    endtask

    // mode 0: no valid, 1: continuous counter, 2: random valid and data
    task automatic test_stream(input int n, input int mode, input string tag);
        int          k = -1;
        int          p;
        int          hs_win = 0;
        bit          prev_hs = 1'b0;
        bit          v;
        bit          exp_dv, exp_f, exp_c, exp_rdy;
        logic [63:0] prev_word = 64'h0;
        logic [63:0] prev_crc = 64'h0;
        logic [63:0] cnt = 64'h100;
        logic [63:0] word;
        logic [63:0] exp_d;
        logic [15:0] exp_fc;
        enable_i = 1'b1;
        bus.s_tvalid_i = 1'b0;
        for (int c = 0; c < n; c++) begin
            @(posedge clk_i); #1;
            k++;
            exp_d = 64'h0; exp_dv = 1'b0; exp_f = 1'b0; exp_c = 1'b0; exp_fc = 16'h0;
            if (k >= 2) begin
                p = (k - 2) % 64;
                if (p == 0) begin
                    exp_d = FAW_WORD; exp_f = 1'b1;
                end else if (!is_data_pos(p)) begin
                    exp_d = prev_crc; exp_c = 1'b1;
                end else begin
                    exp_d = prev_hs ? prev_word : TB_IDLE; exp_dv = prev_hs;
                end
`ifdef QECIPHY_TX_FRAMER_STATS_EN
                exp_fc = 16'((k - 2) / 64 + 1);
`endif
            end
            n_checks++; if (bus.tdata_o !== exp_d) begin
                n_fail++; $display("FAIL %s_tdata k=%0d got %h exp %h", tag, k, bus.tdata_o, exp_d); end
            n_checks++; if (bus.data_valid_o !== exp_dv) begin
                n_fail++; $display("FAIL %s_dvalid k=%0d got %b exp %b", tag, k, bus.data_valid_o, exp_dv); end
            n_checks++; if (bus.faw_boundary_o !== exp_f) begin
                n_fail++; $display("FAIL %s_faw k=%0d got %b exp %b", tag, k, bus.faw_boundary_o, exp_f); end
            n_checks++; if (bus.crc_boundary_o !== exp_c) begin
                n_fail++; $display("FAIL %s_crcb k=%0d got %b exp %b", tag, k, bus.crc_boundary_o, exp_c); end
            n_checks++; if (frame_count_o !== exp_fc) begin
                n_fail++; $display("FAIL %s_fc k=%0d got %0d exp %0d", tag, k, frame_count_o, exp_fc); end

            v = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            word = (mode == 1) ? cnt : {$urandom(), $urandom()};
            bus.s_tvalid_i = v;
            bus.s_tdata_i  = word;
            crc_i          = {$urandom(), $urandom()};
            exp_rdy = (k >= 1) && is_data_pos((k - 1) % 64);
            n_checks++; if (bus.s_tready_o !== exp_rdy) begin
                n_fail++; $display("FAIL %s_tready k=%0d got %b exp %b", tag, k, bus.s_tready_o, exp_rdy); end
            if (k >= 1 && k <= 64 && v && bus.s_tready_o) hs_win++;
            prev_hs   = v && exp_rdy;
            prev_word = word;
            prev_crc  = crc_i;
            if (prev_hs && mode == 1) cnt++;
        end
        if (mode == 1) begin
            n_checks++; if (hs_win != 54) begin
                n_fail++; $display("FAIL %s_per_frame got %0d exp 54", tag, hs_win); end
        end
        enable_i = 1'b0;
        bus.s_tvalid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic test_disable();
        enable_i = 1'b1;
        bus.s_tvalid_i = 1'b0;
        repeat (33) @(posedge clk_i);   // edges 0..32: output now holds slot 30
        #1;
        n_checks++; if ({bus.faw_boundary_o, bus.crc_boundary_o, bus.tdata_o} !== {2'b00, TB_IDLE}) begin
            n_fail++; $display("FAIL dis_slot30 got %b%b %h exp 00 %h", bus.faw_boundary_o, bus.crc_boundary_o, bus.tdata_o, TB_IDLE); end
        enable_i = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            @(posedge clk_i); #1;
            bus.s_tvalid_i = 1'b1;
            bus.s_tdata_i  = {$urandom(), $urandom()};
            n_checks++; if (bus.s_tready_o !== 1'b0) begin
                n_fail++; $display("FAIL dis_tready j=%0d got %b exp 0", j, bus.s_tready_o); end
            if (j >= 2) begin
                n_checks++; if ({bus.tdata_o, bus.data_valid_o, bus.faw_boundary_o, bus.crc_boundary_o} !== 67'h0) begin
                    n_fail++; $display("FAIL dis_outputs j=%0d got %h %b%b%b exp 0", j, bus.tdata_o,
                                       bus.data_valid_o, bus.faw_boundary_o, bus.crc_boundary_o); end
            end
        end
        bus.s_tvalid_i = 1'b0;
        enable_i = 1'b1;
        for (int e = 0; e <= 2; e++) begin
            @(posedge clk_i); #1;
            n_checks++; if (bus.faw_boundary_o !== (e == 2)) begin
                n_fail++; $display("FAIL reen_faw e=%0d got %b exp %b", e, bus.faw_boundary_o, (e == 2)); end
            n_checks++; if (bus.tdata_o !== ((e == 2) ? FAW_WORD : 64'h0)) begin
                n_fail++; $display("FAIL reen_tdata e=%0d got %h", e, bus.tdata_o); end
        end
        enable_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic test_async_reset();
        enable_i = 1'b1;
        bus.s_tvalid_i = 1'b1;
        bus.s_tdata_i  = 64'h0123_4567_89AB_CDEF;
        crc_i          = 64'hFFFF_0000_FFFF_0000;
        repeat (40) @(posedge clk_i);
        #1;
        n_checks++; if (bus.data_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL arst_pre_dvalid got %b exp 1", bus.data_valid_o); end
        #2;
        rst_n_i = 1'b0;
        #1;
        n_checks++; if ({bus.tdata_o, bus.data_valid_o, bus.faw_boundary_o, bus.crc_boundary_o} !== 67'h0) begin
            n_fail++; $display("FAIL arst_outputs got %h %b%b%b exp 0", bus.tdata_o,
                               bus.data_valid_o, bus.faw_boundary_o, bus.crc_boundary_o); end
        n_checks++; if (bus.s_tready_o !== 1'b0) begin
            n_fail++; $display("FAIL arst_tready got %b exp 0", bus.s_tready_o); end
        n_checks++; if (frame_count_o !== 16'h0) begin
            n_fail++; $display("FAIL arst_fc got %0d exp 0", frame_count_o); end
        enable_i = 1'b0;
        bus.s_tvalid_i = 1'b0;
        @(posedge clk_i); #2;
        rst_n_i = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_frame_count();
        logic [15:0] exp_fc;
        enable_i = 1'b1;
        bus.s_tvalid_i = 1'b0;
        repeat (131) @(posedge clk_i);  // edges 0..130: FAWs at 2, 66, 130
        #1;
`ifdef QECIPHY_TX_FRAMER_STATS_EN
        exp_fc = 16'd3;
`else
        exp_fc = 16'd0;
`endif
        n_checks++; if (frame_count_o !== exp_fc) begin
            n_fail++; $display("FAIL fc_three_frames got %0d exp %0d", frame_count_o, exp_fc); end
        n_checks++; if (bus.faw_boundary_o !== 1'b1) begin
            n_fail++; $display("FAIL fc_faw130 got %b exp 1", bus.faw_boundary_o); end
        enable_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        n_checks++; if (frame_count_o !== 16'h0) begin
            n_fail++; $display("FAIL fc_cleared got %0d exp 0", frame_count_o); end
    endtask

    initial begin
        rst_n_i        = 1'b0;
        enable_i       = 1'b0;
        bus.s_tvalid_i = 1'b0;
        bus.s_tdata_i  = 64'h0;
        crc_i          = 64'h0;
        #12;
        test_reset();
        test_stream(200, 0, "idle");
        test_stream(140, 1, "full");
        test_stream(300, 2, "rand");
        test_disable();
        test_async_reset();
        test_frame_count();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
